tt_um_lif_neuron: RTL and testbench

Single leaky integrate-and-fire (LIF) neuron wrapped as a Tiny Tapeout user tile. Each clock it integrates an 8-bit input current into an 8-bit membrane potential with a shift-based leak. It fires a one-cycle spike on threshold crossing, then enters a programmable refractory period. Threshold, leak, refractory length and reset potential are runtime-configurable through the same pins.

---
 rtl/tt_um_lif_neuron_pkg.sv | 21 ++
 rtl/tt_um_lif_neuron_lif_core.sv | 76 +++++++
 rtl/tt_um_lif_neuron.sv | 83 ++++++++
 tb/tb_tt_um_lif_neuron.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_lif_neuron_pkg.sv
// Shared constants for the LIF neuron tile: widths, config defaults, config addresses.
package tt_um_lif_neuron_pkg;

  localparam int unsigned V_W   = 8;
  localparam int unsigned SUM_W = 9;
  localparam int unsigned RC_W  = 4;
  localparam int unsigned LS_W  = 3;

  localparam logic [V_W-1:0]  TH_DEF = 8'd200;
  localparam logic [LS_W-1:0] LS_DEF = 3'd3;
  localparam logic [RC_W-1:0] RP_DEF = 4'd4;
  localparam logic [V_W-1:0]  VR_DEF = 8'd0;

  typedef enum logic [1:0] {
    CFG_TH = 2'd0,
    CFG_LS = 2'd1,
    CFG_RP = 2'd2,
    CFG_VR = 2'd3
  } cfg_addr_e;

endpackage

// File: rtl/tt_um_lif_neuron_lif_core.sv
// Membrane state, leak/integrate/saturate/fire datapath and refractory counter.
module lif_core
  import tt_um_lif_neuron_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [V_W-1:0]  cur_i,
  input  logic [V_W-1:0]  th_i,
  input  logic [LS_W-1:0] ls_i,
  input  logic [RC_W-1:0] rp_i,
  input  logic [V_W-1:0]  vr_i,
  output logic [V_W-1:0]  v_o,
  output logic            spike_o,
  output logic            sat_o,
  output logic            refr_o
);

  logic [V_W-1:0]   v_q, v_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             spike_q, spike_d;
  logic             sat_q, sat_d;
  logic             refr_q, refr_d;
  logic [SUM_W-1:0] sum;
  logic [V_W-1:0]   clamped;

  // Next-state: hold unless enabled; refractory cycles pin V to VR, else integrate and fire.
  always_comb begin
    v_d     = v_q;
    rc_d    = rc_q;
    spike_d = 1'b0;
    sat_d   = sat_q;
    sum     = SUM_W'(v_q) - SUM_W'(v_q >> ls_i) + SUM_W'(cur_i);
    clamped = sum[SUM_W-1] ? {V_W{1'b1}} : sum[V_W-1:0];
    if (en_i) begin
      if (rc_q != '0) begin
        rc_d  = rc_q - RC_W'(1);
        v_d   = vr_i;
        sat_d = 1'b0;
      end else begin
        sat_d = sum[SUM_W-1];
        if (clamped >= th_i) begin
          spike_d = 1'b1;
          v_d     = vr_i;
          rc_d    = rp_i;
        end else begin
          v_d = clamped;
        end
      end
    end
    refr_d = (rc_d != '0);
  end

  // State and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      rc_q    <= '0;
      spike_q <= 1'b0;
      sat_q   <= 1'b0;
      refr_q  <= 1'b0;
    end else begin
      v_q     <= v_d;
      rc_q    <= rc_d;
      spike_q <= spike_d;
      sat_q   <= sat_d;
      refr_q  <= refr_d;
    end
  end

  assign v_o     = v_q;
  assign spike_o = spike_q;
  assign sat_o   = sat_q;
  assign refr_o  = refr_q;

endmodule

// File: rtl/tt_um_lif_neuron.sv
// Tiny Tapeout tile: config register file, control decode and pin mapping around lif_core.
module tt_um_lif_neuron
  import tt_um_lif_neuron_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic            cfg_we;
  logic            run;
  cfg_addr_e       cfg_addr;
  logic [V_W-1:0]  th_q, th_d;
  logic [LS_W-1:0] ls_q, ls_d;
  logic [RC_W-1:0] rp_q, rp_d;
  logic [V_W-1:0]  vr_q, vr_d;
  logic [V_W-1:0]  v;
  logic            spike;
  logic            sat;
  logic            refr;
  logic            unused_ok;

  assign cfg_we    = uio_in[7];
  assign run       = uio_in[6];
  assign cfg_addr  = cfg_addr_e'(uio_in[5:4]);
  assign unused_ok = ^uio_in[3:0];

  // Config write decode; only the addressed register changes.
  always_comb begin
    th_d = th_q;
    ls_d = ls_q;
    rp_d = rp_q;
    vr_d = vr_q;
    if (cfg_we) begin
      case (cfg_addr)
        CFG_TH: th_d = ui_in;
        CFG_LS: ls_d = ui_in[LS_W-1:0];
        CFG_RP: rp_d = ui_in[RC_W-1:0];
        CFG_VR: vr_d = ui_in;
        default: ;
      endcase
    end
  end

  // Config registers return to their defaults on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      th_q <= TH_DEF;
      ls_q <= LS_DEF;
      rp_q <= RP_DEF;
      vr_q <= VR_DEF;
    end else begin
      th_q <= th_d;
      ls_q <= ls_d;
      rp_q <= rp_d;
      vr_q <= vr_d;
    end
  end

  lif_core u_core (
    .clk     (clk),
    .rst     (rst),
    .en_i    (run & ~cfg_we),
    .cur_i   (ui_in),
    .th_i    (th_q),
    .ls_i    (ls_q),
    .rp_i    (rp_q),
    .vr_i    (vr_q),
    .v_o     (v),
    .spike_o (spike),
    .sat_o   (sat),
    .refr_o  (refr)
  );

  assign uo_out  = v;
  assign uio_out = {5'b0, sat, refr, spike};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_lif_neuron.sv
// Bench for tt_um_lif_neuron: arithmetic reference model plus directed literal checks.
module tb_tt_um_lif_neuron;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state (plain integers)
  int m_v, m_rc, m_spike, m_sat;
  int m_th, m_ls, m_rp, m_vr;

  always #5 clk = ~clk;

  tt_um_lif_neuron dut (
    .clk     (clk),
    .rst     (rst),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit we, input bit run,
                                     input int a, input int d);
    int sum;
    if (r) begin
      m_v = 0; m_rc = 0; m_spike = 0; m_sat = 0;
      m_th = 200; m_ls = 3; m_rp = 4; m_vr = 0;
    end else if (we) begin
      case (a)
        0: m_th = d;
        1: m_ls = d % 8;
        2: m_rp = d % 16;
        default: m_vr = d;
      endcase
      m_spike = 0;
    end else if (run) begin
      if (m_rc > 0) begin
        m_rc = m_rc - 1; m_v = m_vr; m_spike = 0; m_sat = 0;
      end else begin
        sum = m_v - m_v / (1 << m_ls) + d;
        m_sat = (sum > 255) ? 1 : 0;
        if (sum > 255) sum = 255;
        if (sum >= m_th) begin
          m_spike = 1; m_v = m_vr; m_rc = m_rp;
        end else begin
          m_spike = 0; m_v = sum;
        end
      end
    end else begin
      m_spike = 0;
    end
  endfunction

  // One clock: drive inputs, clock, advance model, settle 1 time unit past the edge.
  task automatic tick(input bit r, input bit we, input bit run,
                      input logic [1:0] a, input logic [7:0] d);
    rst    = r;
    ui_in  = d;
    uio_in = {we, run, a, 4'($urandom)};
    @(posedge clk);
    model_step(r, we, run, int'(a), int'(d));
    #1;
    chk_en = 1'b1;
  endtask

  task automatic run_i(input logic [7:0] i);
    tick(1'b0, 1'b0, 1'b1, 2'd0, i);
  endtask

  task automatic cfg(input logic [1:0] a, input logic [7:0] d, input bit run);
    tick(1'b0, 1'b1, run, a, d);
  endtask

  task automatic hold();
    tick(1'b0, 1'b0, 1'b0, 2'($urandom), 8'($urandom));
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++)
      tick(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
  endtask

  // Every-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("v",         int'(uo_out),      m_v);
      check("spike",     int'(uio_out[0]),  m_spike);
      check("refr",      int'(uio_out[1]),  (m_rc != 0) ? 1 : 0);
      check("sat",       int'(uio_out[2]),  m_sat);
      check("uio_hi",    int'(uio_out[7:3]), 0);
      check("uio_oe",    int'(uio_oe),      15);
    end
  end

  int nspk;
  int prev;

  initial begin
    // Reset with random inputs
    do_reset(2);
    check("rst_uo",  int'(uo_out),  0);
    check("rst_uio", int'(uio_out), 0);
    check("rst_oe",  int'(uio_oe),  15);

    // Leak equilibrium with defaults
    nspk = 0;
    for (int k = 0; k < 100; k++) begin
      run_i(8'd10);
      nspk += int'(uio_out[0]);
    end
    check("eq_range", (uo_out >= 8'd80 && uo_out <= 8'd87) ? 1 : 0, 1);
    check("eq_nospk", nspk, 0);
    prev = int'(uo_out);
    for (int k = 0; k < 60; k++) begin
      run_i(8'd0);
      check("decay_mono", (int'(uo_out) <= prev) ? 1 : 0, 1);
      prev = int'(uo_out);
    end
    check("decay_floor", (uo_out <= 8'd7) ? 1 : 0, 1);

    // Integrate and fire with LS=7; config write wins over run
    do_reset(1);
    cfg(2'd1, 8'd7, 1'b1);
    check("cfg_prio_v", int'(uo_out), 0);
    run_i(8'd50); check("int_1", int'(uo_out), 50);
    run_i(8'd50); check("int_2", int'(uo_out), 100);
    run_i(8'd50); check("int_3", int'(uo_out), 150);
    run_i(8'd50); check("int_4", int'(uo_out), 199);
    run_i(8'd50); check("fire_uio", int'(uio_out), 3);
    check("fire_v", int'(uo_out), 0);
    for (int k = 0; k < 3; k++) begin
      run_i(8'd50);
      check("refr_uio", int'(uio_out), 2);
      check("refr_v", int'(uo_out), 0);
    end
    run_i(8'd50); check("refr_end", int'(uio_out), 0);
    run_i(8'd50); check("restart", int'(uo_out), 50);

    // Freeze refractory with run=0; RP write does not disturb RC in progress
    run_i(8'd50); run_i(8'd50); run_i(8'd50);
    run_i(8'd50); check("fire2", int'(uio_out[0]), 1);
    run_i(8'd50);
    for (int k = 0; k < 3; k++) begin
      hold();
      check("frz_refr", int'(uio_out), 2);
    end
    cfg(2'd2, 8'd1, 1'b1);
    check("frz_cfg", int'(uio_out), 2);
    run_i(8'd50); run_i(8'd50); check("resume_refr", int'(uio_out[1]), 1);
    run_i(8'd50); check("resume_done", int'(uio_out[1]), 0);
    run_i(8'd50); check("resume_v", int'(uo_out), 50);
    run_i(8'd50); run_i(8'd50); run_i(8'd50);
    run_i(8'd50); check("fire_rp1", int'(uio_out), 3);
    run_i(8'd50); check("rp1_last", int'(uio_out), 0);
    run_i(8'd50); check("rp1_v", int'(uo_out), 50);

    // Saturation, then nonzero reset potential
    do_reset(1);
    cfg(2'd0, 8'd255, 1'b0);
    cfg(2'd1, 8'd7, 1'b0);
    run_i(8'd200); check("sat_v1", int'(uo_out), 200);
    run_i(8'd200); check("sat_fire", int'(uio_out), 7);
    check("sat_v", int'(uo_out), 0);
    cfg(2'd3, 8'd20, 1'b1);
    for (int k = 0; k < 4; k++) begin
      run_i(8'd200);
      check("vr_refr_v", int'(uo_out), 20);
    end
    run_i(8'd200); check("vr_int", int'(uo_out), 220);
    run_i(8'd200); check("vr_fire", int'(uio_out), 7);
    check("vr_post", int'(uo_out), 20);

    // TH=0 with RP=0 fires every run cycle
    cfg(2'd0, 8'd0, 1'b0);
    cfg(2'd2, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) run_i(8'd200);
    for (int k = 0; k < 3; k++) begin
      run_i(8'd200);
      check("th0_fire", int'(uio_out), 1);
      check("th0_v", int'(uo_out), 20);
    end

    // LS=0 is full leak: V equals I
    cfg(2'd0, 8'd255, 1'b0);
    cfg(2'd1, 8'd0, 1'b0);
    run_i(8'd77);  check("ls0_a", int'(uo_out), 77);
    run_i(8'd77);  check("ls0_b", int'(uo_out), 77);
    run_i(8'd254); check("ls0_c", int'(uo_out), 254);

    // Reset mid-integration, then restart from V=0 with defaults
    run_i(8'd30);
    do_reset(1);
    check("mid_rst", int'(uo_out), 0);
    run_i(8'd5); check("post_rst", int'(uo_out), 5);

    // Mixed random operations against the model
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       cfg(2'($urandom), 8'($urandom), 1'($urandom));
        1:       hold();
        default: run_i(8'($urandom_range(0, 120)));
      endcase
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
